// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the six-digit multiplexed seven-segment driver.
// Holds the active-low a..g segment patterns (bit 0 = a, bit 6 = g),
// the digit-slot count and a helper that builds the active-low digit enable.
package seg_scan_driver_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low a..g patterns; dp is handled separately by the top level.
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Active-low one-hot enable for digit slot idx (0..5).
    function automatic logic [5:0] digit_enable(input logic [2:0] idx);
        logic [5:0] onehot;
        onehot = 6'b000001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// bcd_to_seg: combinational BCD to seven-segment decoder.
//   bcd [3:0] in  : digit value; 10..15 are not valid BCD
//   seg [6:0] out : active-low a..g; non-BCD values show a dash (g only)
module bcd_to_seg
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit decode; anything outside 0..9 falls through to the dash.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a six-digit HH:MM:SS display.
//   clk, reset          : clock and asynchronous active-high reset
//   hour_tens..sec_ones : BCD digits, sampled once per frame at the 5->0 wrap
//   hlz                 : suppress a leading zero on hour_tens
//   blank               : turn all digit enables off (scanning continues)
//   dig_sel [5:0]       : active-low digit enables, bit i = slot i
//   seg [7:0]           : active-low segments a..g on bits 0..6, dp on bit 7
// Each slot lasts SCAN_DIV cycles: one dead cycle with all digits off while
// seg settles on the new pattern, then the slot's digit enabled.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hour_tens,
    input  logic [3:0] hour_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       hlz,
    input  logic       blank,
    output logic [5:0] dig_sel,
    output logic [7:0] seg
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]     presc_r;
    logic [2:0]        idx_r;
    logic [FW-1:0]     frame_r;
    logic              blink_r;
    logic              started_r;
    logic [5:0][3:0]   snap_r;

    logic              tick_s;
    logic              wrap_s;
    logic [2:0]        idx_next_s;
    logic [FW-1:0]     frame_next_s;
    logic              blink_next_s;
    logic [5:0][3:0]   in_digits_s;
    logic [5:0][3:0]   snap_next_s;
    logic [3:0]        sel_digit_s;
    logic [6:0]        dec_s;
    logic              lz_s;
    logic              dp_on_s;
    logic [7:0]        seg_next_s;
    logic [5:0]        dig_next_s;

    assign tick_s = (presc_r == PW'(SCAN_DIV - 1));
    assign wrap_s = tick_s && (idx_r == 3'd5);

    assign in_digits_s = {sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens};

    // Slot index, frame counter, blink phase and snapshot next-state.
    always_comb begin
        idx_next_s   = idx_r;
        frame_next_s = frame_r;
        blink_next_s = blink_r;
        snap_next_s  = snap_r;
        if (tick_s) begin
            if (idx_r == 3'd5) begin
                idx_next_s = 3'd0;
            end else begin
                idx_next_s = idx_r + 3'd1;
            end
        end else begin
            idx_next_s = idx_r;
        end
        if (wrap_s) begin
            // Fresh snapshot is decoded in the same edge it is captured,
            // so slot 0 of the new frame already shows the new digits.
            snap_next_s = in_digits_s;
            if (frame_r == FW'(BLINK_FRAMES - 1)) begin
                frame_next_s = '0;
                blink_next_s = ~blink_r;
            end else begin
                frame_next_s = frame_r + FW'(1);
            end
        end else begin
            snap_next_s = snap_r;
        end
    end

    // Pick the snapshot digit for the slot that becomes active at this tick.
    always_comb begin
        sel_digit_s = snap_next_s[0];
        case (idx_next_s)
            3'd0:    sel_digit_s = snap_next_s[0];
            3'd1:    sel_digit_s = snap_next_s[1];
            3'd2:    sel_digit_s = snap_next_s[2];
            3'd3:    sel_digit_s = snap_next_s[3];
            3'd4:    sel_digit_s = snap_next_s[4];
            3'd5:    sel_digit_s = snap_next_s[5];
            default: sel_digit_s = snap_next_s[0];
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (sel_digit_s),
        .seg (dec_s)
    );

    // Output next-state: seg changes only on ticks; dig_sel is off during the
    // dead cycle, while blanked, and before the first slot after reset.
    always_comb begin
        lz_s    = hlz && (idx_next_s == 3'd0) && (sel_digit_s == 4'd0);
        dp_on_s = blink_next_s && ((idx_next_s == 3'd1) || (idx_next_s == 3'd3));
        if (tick_s) begin
            seg_next_s = {~dp_on_s, (lz_s ? SEG_OFF : dec_s)};
        end else begin
            seg_next_s = seg;
        end
        if (blank || tick_s || !started_r) begin
            dig_next_s = 6'b111111;
        end else begin
            dig_next_s = digit_enable(idx_r);
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r   <= '0;
            idx_r     <= 3'd0;
            frame_r   <= '0;
            blink_r   <= 1'b0;
            started_r <= 1'b0;
            snap_r    <= '0;
        end else begin
            presc_r   <= tick_s ? '0 : presc_r + PW'(1);
            idx_r     <= idx_next_s;
            frame_r   <= frame_next_s;
            blink_r   <= blink_next_s;
            started_r <= started_r | tick_s;
            snap_r    <= snap_next_s;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_sel <= 6'b111111;
            seg     <= 8'hFF;
        end else begin
            dig_sel <= dig_next_s;
            seg     <= seg_next_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, table-driven bench for seg_scan_driver with SCAN_DIV=4 and
// BLINK_FRAMES=2. cyc counts rising edges since the last reset release;
// with SCAN_DIV=4 a tick lands on every edge where cyc%4==0, idx after
// edge cyc is (cyc/4)%6, and frame f (f>=1) begins at edge 24*f.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       hlz, blank;
    logic [5:0] dig_sel;
    logic [7:0] seg;

    int cyc = 0;
    int nvec = 0;
    int nfail = 0;

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .hour_tens (hour_tens),
        .hour_ones (hour_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .hlz       (hlz),
        .blank     (blank),
        .dig_sel   (dig_sel),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0][3:0] d;    // d[0]=hour_tens .. d[5]=sec_ones
        logic            hlz;
        logic [5:0][7:0] exp;  // expected seg per slot, dp included
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        hour_tens = v.d[0]; hour_ones = v.d[1];
        min_tens  = v.d[2]; min_ones  = v.d[3];
        sec_tens  = v.d[4]; sec_ones  = v.d[5];
        hlz       = v.hlz;
    endtask

    function automatic logic [5:0] model_dig(input int c);
        logic [5:0] oh;
        if (c % 4 == 0) return 6'h3F;
        oh = 6'b000001 << ((c / 4) % 6);
        return ~oh;
    endfunction

    initial begin
        // frame 1, blink phase 0
        vecs[0] = '{d: {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, hlz: 1'b0,
                    exp: {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9}};
        // frame 2, blink phase 1: hlz blanks slot 0, dash on slot 5, dp on 1 and 3
        vecs[1] = '{d: {4'hC, 4'd5, 4'd7, 4'd3, 4'd2, 4'd0}, hlz: 1'b1,
                    exp: {8'hBF, 8'h92, 8'h78, 8'hB0, 8'h24, 8'hFF}};
        // frame 3, blink phase 1: hlz=0 shows the leading zero
        vecs[2] = '{d: {4'd1, 4'd0, 4'd9, 4'd5, 4'd8, 4'd0}, hlz: 1'b0,
                    exp: {8'hF9, 8'hC0, 8'h10, 8'h92, 8'h00, 8'hC0}};
        // frame 4, blink phase 0 again; hlz has no effect on a nonzero digit
        vecs[3] = '{d: {4'd9, 4'd3, 4'hF, 4'hA, 4'd0, 4'd1}, hlz: 1'b1,
                    exp: {8'h90, 8'hB0, 8'hBF, 8'hBF, 8'hC0, 8'hF9}};

        reset = 1'b1; blank = 1'b0; hlz = 1'b0;
        hour_tens = 4'd0; hour_ones = 4'd0; min_tens = 4'd0;
        min_ones = 4'd0; sec_tens = 4'd0; sec_ones = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_dig", {2'b00, dig_sel}, 8'h3F);
        check("rst_seg", seg, 8'hFF);

        // Release and confirm nothing lights before the first tick at edge 4.
        reset = 1'b0; cyc = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("pre_tick_dig", {2'b00, dig_sel}, 8'h3F);
            check("pre_tick_seg", seg, 8'hFF);
        end
        step();
        check("first_tick_seg", seg, 8'hC0);
        check("first_tick_dig", {2'b00, dig_sel}, 8'h3F);
        step();
        check("first_slot_dig", {2'b00, dig_sel}, 8'h3D);

        // Table-driven frames: inputs applied just before each wrap edge.
        for (int f = 0; f < 4; f++) begin
            step_to(24 * (f + 1) - 1);
            apply(vecs[f]);
            for (int s = 0; s < 6; s++) begin
                for (int k = 0; k < 4; k++) begin
                    logic [5:0] oh;
                    step_to(24 * (f + 1) + 4 * s + k);
                    oh = 6'b000001 << s;
                    check("frame_seg", seg, vecs[f].exp[s]);
                    check("frame_dig", {2'b00, dig_sel}, (k == 0) ? 8'h3F : {2'b00, ~oh});
                end
            end
        end

        // Snapshot: min_ones changes mid-frame (idx=2) and shows only next frame.
        step_to(119);
        hour_tens = 4'd1; hour_ones = 4'd2; min_tens = 4'd3;
        min_ones = 4'd4; sec_tens = 4'd5; sec_ones = 4'd6; hlz = 1'b0;
        step_to(129);
        min_ones = 4'd7;
        step_to(132);
        check("tear_same_frame", seg, 8'h99);
        step_to(148);
        check("next_frame_s1_dp", seg, 8'h24);
        step_to(156);
        check("next_frame_s3_dp", seg, 8'h78);

        // Blank for 10 cycles, then compare against the free-running model.
        step_to(161);
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("blank_dig", {2'b00, dig_sel}, 8'h3F);
        end
        blank = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("unblank_dig", {2'b00, dig_sel}, {2'b00, model_dig(cyc)});
        end

        // Reset mid-slot with slot 3 lit: takes effect without a clock edge.
        for (int i = 0; i < 30; i++) begin
            if ((cyc % 4 == 2) && ((cyc / 4) % 6 == 3)) break;
            step();
        end
        check("mid_slot_dig", {2'b00, dig_sel}, 8'h37);
        reset = 1'b1;
        #1;
        check("async_rst_dig", {2'b00, dig_sel}, 8'h3F);
        check("async_rst_seg", seg, 8'hFF);
        step(); step();
        check("held_rst_dig", {2'b00, dig_sel}, 8'h3F);
        check("held_rst_seg", seg, 8'hFF);
        reset = 1'b0; cyc = 0;
        step_to(3);
        check("rerst_pre_seg", seg, 8'hFF);
        step();
        check("rerst_tick_seg", seg, 8'hC0);
        step();
        check("rerst_slot_dig", {2'b00, dig_sel}, 8'h3D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit slot (minimum 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 417, meaning full 6-digit frames per colon-blink phase (minimum 1).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones  input  4 each  BCD digits from the time counters.
REQ-006 SHALL have port hlz  input  1  1 = suppress leading zero on hour_tens.
REQ-007 SHALL have port blank  input  1  1 = all digits off.
REQ-008 SHALL have port dig_sel  output  6  digit enables, active-low; bit i drives digit slot i.
REQ-009 SHALL have port seg  output  8  segments, active-low; bits 0..6 = a..g, bit 7 = dp.

Function
REQ-010 SHALL count a prescaler 0..SCAN_DIV-1 and wrap; a tick occurs in the cycle where the prescaler equals SCAN_DIV-1.
REQ-011 SHALL hold a digit index idx 0..5; on each tick idx advances by 1, and from 5 it wraps to 0.
REQ-012 Slot map SHALL be: idx0 hour_tens, idx1 hour_ones, idx2 min_tens, idx3 min_ones, idx4 sec_tens, idx5 sec_ones.
REQ-013 SHALL capture all six input digits into snapshot registers on the tick where idx wraps 5->0; only snapshot values are ever displayed, so there is no mid-frame tearing.
REQ-014 On a tick edge, dig_sel SHALL go to 6'b111111 and seg SHALL load the pattern for the new idx; on the following edge, dig_sel bit idx SHALL go low, giving exactly one dead cycle per slot.
REQ-015 Decode (a..g lit) SHALL be the standard 0-9 set: 0=0xC0, 1=0xF9, 2=0xA4, 3=0xB0, 4=0x99, 5=0x92, 6=0x82, 7=0xF8, 8=0x80, 9=0x90 (dp off).
REQ-016 Non-BCD digit values 10-15 SHALL display a dash, g only: 0xBF.
REQ-017 When hlz=1 and the snapshot hour_tens is 0, slot 0 SHALL output seg 0xFF; dig_sel is still scanned.
REQ-018 A frame counter SHALL increment on each 5->0 wrap; on reaching BLINK_FRAMES-1 it SHALL clear and toggle blink_phase.
REQ-019 When blink_phase=1, dp (seg bit 7) SHALL be low on slots 1 and 3 only; on all other slots and phases dp SHALL be high.
REQ-020 blank=1 SHALL force dig_sel=6'b111111 within one cycle, without stopping the prescaler, idx, snapshot or blink; releasing blank SHALL resume at the current idx.
REQ-021 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-022 While reset=1, the block SHALL hold: prescaler 0, idx 0, frame counter 0, blink_phase 0, snapshots 0, dig_sel 6'b111111, seg 0xFF.
REQ-023 Reset asserted mid-slot SHALL take effect immediately, with no clock required.
REQ-024 After reset releases, the first tick SHALL occur SCAN_DIV cycles later, and idx SHALL become 1 at that tick.

Structure
REQ-025 The shared package SHALL hold the seven-segment pattern constants (0-9, dash, off) and the digit-count constant 6.
REQ-026 The BCD-to-segment decode SHALL be a sub-module, bcd_to_seg: 4-bit in, 7-bit active-low out, combinational, including the dash for 10-15.
REQ-027 The expected size is about 150-250 RTL lines, excluding the package.

Verification (bench SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 Hold reset, then release -> seg=0xFF and dig_sel=0x3F until the first tick; the first tick occurs 4 cycles after release.
REQ-029 Inputs 1,2,3,4,5,6 applied before a 5->0 wrap -> the following frame shows slot patterns 0xF9,0xA4,0xB0,0x99,0x92,0x82, each slot with one dead cycle, then dig_sel bit low for 3 cycles.
REQ-030 Change min_ones 4->7 while idx=2 -> slot 3 still shows 0x99 in that frame, and shows 0xF8 from the next frame.
REQ-031 hour_tens=0 with hlz=1 -> slot 0 seg=0xFF; with hlz=0 -> 0xC0. sec_ones=4'hC -> slot 5 seg=0xBF.
REQ-032 Run 4 frames -> slot 1 and slot 3 dp is low in frames 2-3 only, e.g. digit 2 shows as 0x24 when lit with dp.
REQ-033 Assert reset at idx=3 mid-slot, and separately assert blank for 10 cycles -> reset: all outputs return immediately to REQ-022 values; blank: dig_sel=0x3F within 1 cycle, and on release idx matches a free-running reference model.
